dram_cmd_seq: RTL

//  Per-request DRAM command sequencer, directly downstream of the open-row policy table.

---
 rtl/dram_pkg.sv | 14 +
 rtl/dram_timer.sv | 18 +
 rtl/dram_cmd_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared widths, command/row-status encodings and sequencer states for dram_cmd_seq.
package dram_pkg;
  localparam int ROW_BITS = 16;
  localparam int COL_BITS = 10;
  // NOP is expressed as cmd_valid=0; the remaining eight commands fill the 3-bit code.
  typedef enum logic [2:0] {
    CMD_ACT, CMD_PRE, CMD_PREA, CMD_RD, CMD_WR, CMD_RDA, CMD_WRA, CMD_REF
  } cmd_t;
  typedef enum logic [1:0] {RS_IDLE, RS_HIT, RS_MISS, RS_CONFLICT} row_stat_t;
  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_CL,
    S_PREA, S_WAIT_RPA, S_REF, S_WAIT_RFC
  } seq_state_t;
endpackage

// File: rtl/dram_timer.sv
// dram_timer: loadable 8-bit saturating down-counter with zero flag.
module dram_timer (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       zero
);
  logic [7:0] value_q, value_d;
  always_comb value_d = load ? load_val : (value_q == 8'd0 ? value_q : value_q - 8'd1);
  always_ff @(posedge CLK) begin
    if (!nRST) value_q <= '0;
    else value_q <= value_d;
  end
  assign value = value_q;
  assign zero = value_q == 8'd0;
endmodule

// File: rtl/dram_cmd_seq.sv
// dram_cmd_seq: per-request DRAM command sequencer (PRE/ACT/RD/WR/PREA/REF) driven by an open-row policy.
// Define CLOSED_PAGE_EN to issue RDA/WRA and close the row on every access.
module dram_cmd_seq
  import dram_pkg::*;
#(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_CL  = 6,
  parameter int T_RFC = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_bg,
  input  logic [1:0]          req_bank,
  input  logic [ROW_BITS-1:0] req_row,
  input  logic [COL_BITS-1:0] req_col,
  output logic                pol_req_en,
  output logic [1:0]          pol_bg,
  output logic [1:0]          pol_bank,
  output logic [ROW_BITS-1:0] pol_row,
  output logic                pol_row_resolve,
  output logic                pol_refresh,
  input  logic [1:0]          pol_row_stat,
  input  logic [ROW_BITS-1:0] pol_row_conflict,
  input  logic                pol_all_closed,
  input  logic                ref_req,
  output logic                ref_ack,
  output logic                cmd_valid,
  output logic [2:0]          cmd_type,
  output logic [1:0]          cmd_bg,
  output logic [1:0]          cmd_bank,
  output logic [ROW_BITS-1:0] cmd_row,
  output logic [COL_BITS-1:0] cmd_col,
  output logic                rsp_done
);
`ifdef CLOSED_PAGE_EN
  localparam int T_RW = T_CL > T_RP ? T_CL : T_RP;
`else
  localparam int T_RW = T_CL;
`endif
  seq_state_t state_q, state_d;
  logic write_q, write_d, rsp_done_q, rsp_done_d, accept;
  logic [1:0] bg_q, bg_d, bank_q, bank_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic t_load, t_zero;
  logic [7:0] t_val, t_cnt;
  row_stat_t stat;

  dram_timer u_timer (
    .CLK(CLK), .nRST(nRST), .load(t_load), .load_val(t_val), .value(t_cnt), .zero(t_zero)
  );

  assign stat = row_stat_t'(pol_row_stat);
  assign req_ready = state_q == S_IDLE && !ref_req;
  assign accept = req_ready && req_valid;
  assign pol_bg = bg_q;
  assign pol_bank = bank_q;
  assign pol_row = row_q;
  assign rsp_done = rsp_done_q;
  assign ref_ack = (state_q == S_REF || state_q == S_WAIT_RFC) && t_zero;
  // Counter is loaded on entry to a command state, so it already holds T-1 during the command cycle.
  assign t_load = state_d inside {S_PRE, S_ACT, S_RW, S_PREA, S_REF};
  assign t_val = state_d == S_ACT ? 8'(T_RCD - 1) : state_d == S_RW ? 8'(T_RW - 1) :
                 state_d == S_REF ? 8'(T_RFC - 1) : 8'(T_RP - 1);
  assign rsp_done_d = (state_q == S_RW || state_q == S_WAIT_CL) && t_cnt == 8'(T_RW - T_CL);

  always_comb begin
    state_d = state_q;
    write_d = accept ? req_write : write_q;
    bg_d = accept ? req_bg : bg_q;
    bank_d = accept ? req_bank : bank_q;
    row_d = accept ? req_row : row_q;
    col_d = accept ? req_col : col_q;
    pol_req_en = 1'b0;
    pol_row_resolve = 1'b0;
    pol_refresh = 1'b0;
    cmd_valid = 1'b0;
    cmd_type = 3'd0;
    cmd_bg = '0;
    cmd_bank = '0;
    cmd_row = '0;
    cmd_col = '0;
    case (state_q)
      S_IDLE: state_d = ref_req ? (pol_all_closed ? S_REF : S_PREA) : req_valid ? S_CHECK : S_IDLE;
      S_CHECK: begin
        pol_req_en = 1'b1;
        state_d = stat == RS_HIT ? S_RW : stat == RS_MISS ? S_ACT :
                  stat == RS_CONFLICT ? S_PRE : S_CHECK;
      end
      S_PRE, S_WAIT_RP: begin
        if (state_q == S_PRE) begin
          pol_req_en = 1'b1;
          pol_row_resolve = 1'b1;
          cmd_valid = 1'b1;
          cmd_type = CMD_PRE;
          cmd_bg = bg_q;
          cmd_bank = bank_q;
          cmd_row = pol_row_conflict;
        end
        state_d = t_zero ? S_CHECK : S_WAIT_RP;
      end
      S_ACT, S_WAIT_RCD: begin
        if (state_q == S_ACT) begin
          cmd_valid = 1'b1;
          cmd_type = CMD_ACT;
          cmd_bg = bg_q;
          cmd_bank = bank_q;
          cmd_row = row_q;
        end
        state_d = t_zero ? S_RW : S_WAIT_RCD;
      end
      S_RW, S_WAIT_CL: begin
        if (state_q == S_RW) begin
          cmd_valid = 1'b1;
`ifdef CLOSED_PAGE_EN
          cmd_type = write_q ? CMD_WRA : CMD_RDA;
          pol_req_en = 1'b1;
          pol_row_resolve = 1'b1;
`else
          cmd_type = write_q ? CMD_WR : CMD_RD;
`endif
          cmd_bg = bg_q;
          cmd_bank = bank_q;
          cmd_col = col_q;
        end
        state_d = t_zero ? S_IDLE : S_WAIT_CL;
      end
      S_PREA, S_WAIT_RPA: begin
        cmd_valid = state_q == S_PREA;
        cmd_type = CMD_PREA;
        state_d = t_zero ? S_REF : S_WAIT_RPA;
      end
      S_REF, S_WAIT_RFC: begin
        pol_refresh = state_q == S_REF;
        cmd_valid = state_q == S_REF;
        cmd_type = state_q == S_REF ? CMD_REF : 3'd0;
        state_d = t_zero ? S_IDLE : S_WAIT_RFC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      bg_q <= '0;
      bank_q <= '0;
      row_q <= '0;
      col_q <= '0;
      rsp_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      bg_q <= bg_d;
      bank_q <= bank_d;
      row_q <= row_d;
      col_q <= col_d;
      rsp_done_q <= rsp_done_d;
    end
  end
endmodule
